sc_chain_monitor: RTL and testbench
===================================

SC_CHAIN_MONITOR -- requirements
Module: sc_chain_monitor

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 80, meaning scan-chain length in flip-flops (sc_head-to-sc_tail latency in clk cycles); legal range 2..(2^CNT_W)-1.
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum number of in-flight injected pulses tracked.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the timestamp counter and pulses_checked.
REQ-004 SHALL have parameter ERR_W, default 8, meaning width of err_count.
REQ-005 SHALL have port clk, input, 1, operating clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port Test_en, input, 1, monitor enable; low forces the IDLE state.
REQ-008 SHALL have port sc_head, input, 1, copy of the bit injected into the scan-chain head.
REQ-009 SHALL have port sc_tail, input, 1, bit observed at the scan-chain tail.
REQ-010 SHALL have port mismatch, output, 1, registered one-cycle pulse on a compare failure.
REQ-011 SHALL have port err_count, output, ERR_W, saturating count of mismatches.
REQ-012 SHALL have port pulses_checked, output, CNT_W, saturating count of correctly received pulses.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when an injected pulse is dropped because the tracker is full.
REQ-014 SHALL have port checking, output, 1, high while the state is CHECK.

Function
REQ-015 SHALL implement a free-running CNT_W-bit timestamp counter cyc that increments by 1 every cycle, wraps modulo 2^CNT_W, and is independent of Test_en.
REQ-016 SHALL implement states IDLE, WARMUP and CHECK.
REQ-017 SHALL transition IDLE->WARMUP on an edge where Test_en=1, loading a warm-up counter with CHAIN_LEN.
REQ-018 SHALL decrement the warm-up counter each WARMUP edge and transition WARMUP->CHECK on the edge where it reaches 0, so that exactly CHAIN_LEN WARMUP edges occur.
REQ-019 SHALL transition any state->IDLE on an edge where Test_en=0 and, on that same edge, flush the tracker; err_count, pulses_checked and overflow are held, not cleared.
REQ-020 SHALL, in WARMUP and CHECK, push (cyc+CHAIN_LEN) mod 2^CNT_W into a DEPTH-entry FIFO on every edge with sc_head=1; in IDLE, sc_head SHALL be ignored.
REQ-021 SHALL define expected=1 on an edge when the FIFO is non-empty and the FIFO head equals cyc; an expected entry SHALL be popped on that edge in any non-IDLE state.
REQ-022 SHALL, in CHECK only, compare sc_tail against expected: if sc_tail=1 and expected=1 it increments pulses_checked; if sc_tail=0 and expected=1 (missing pulse) or sc_tail=1 and expected=0 (spurious pulse) it asserts mismatch the next cycle and increments err_count.
REQ-023 SHALL perform no compares, assert no mismatch and change no counters in IDLE or WARMUP.
REQ-024 SHALL allow a push and a pop on the same edge, with FIFO occupancy unchanged.
REQ-025 SHALL, when the FIFO is full and a push occurs without a simultaneous pop, drop the push and set overflow; with a simultaneous pop the push SHALL succeed.
REQ-026 SHALL saturate err_count at 2^ERR_W-1 and pulses_checked at 2^CNT_W-1; neither wraps.
REQ-027 SHALL register all outputs, with mismatch high for exactly one cycle per failing edge.

Reset
REQ-028 SHALL, on Reset=1 and asynchronously, set state=IDLE, cyc=0, the warm-up counter to 0, the FIFO to empty, mismatch=0, err_count=0, pulses_checked=0, overflow=0 and checking=0.
REQ-029 SHALL, on a Reset assertion mid-operation, discard in-flight entries and SHALL require a fresh CHAIN_LEN-edge WARMUP after release.

Verification
REQ-030 SHALL cover this scenario: Test_en=1 and an ideal 80-stage shift register with one sc_head pulse every 20 cycles for 1000 cycles -> err_count=0, mismatch never high, pulses_checked counts every pulse sampled in CHECK, overflow=0.
REQ-031 SHALL cover this scenario: the chain is modelled as 79 stages -> every pulse yields two mismatches (spurious, then missing), so err_count increments by 2 per pulse.
REQ-032 SHALL cover this scenario: sc_tail is forced to 1 during WARMUP -> no mismatch; the first check occurs on WARMUP entry edge +81.
REQ-033 SHALL cover this scenario: with DEPTH=4, sc_head=1 for 6 consecutive cycles -> first 4 tracked, overflow=1 from the 5th push onward.
REQ-034 SHALL cover this scenario: Test_en dropped with 3 pulses in flight, then re-raised -> no mismatch from the flushed pulses and the counters are retained.
REQ-035 SHALL cover this scenario: Reset pulsed mid-CHECK -> all outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sc_chain_monitor.sv
// sc_chain_monitor: checks that every pulse injected at the scan-chain head
// reappears at the tail exactly CHAIN_LEN cycles later. Each injected pulse is
// remembered as its expected arrival timestamp; arrivals are compared in CHECK.
module sc_chain_monitor #(
    parameter int unsigned CHAIN_LEN = 80,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Test_en,
    input  logic             sc_head,
    input  logic             sc_tail,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] pulses_checked,
    output logic             overflow,
    output logic             checking
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] warm_q, warm_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] pulses_checked_q, pulses_checked_d;
    logic             overflow_q, overflow_d;
    logic             checking_q, checking_d;

    logic active, expected, do_pop, do_push, push_ok;

    // Next-state: FSM sequencing, timestamp FIFO push/pop and tail compare.
    always_comb begin
        state_d          = state_q;
        cyc_d            = cyc_q + CNT_W'(1);
        warm_d           = warm_q;
        mem_d            = mem_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        occ_d            = occ_q;
        mismatch_d       = 1'b0;
        err_count_d      = err_count_q;
        pulses_checked_d = pulses_checked_q;
        overflow_d       = overflow_q;

        active   = Test_en && (state_q != IDLE);
        expected = (occ_q != '0) && (mem_q[rd_ptr_q] == cyc_q);
        do_pop   = active && expected;
        do_push  = active && sc_head;
        // A full tracker still accepts a push when the head entry leaves on the same edge.
        push_ok  = do_push && ((occ_q != OW'(DEPTH)) || do_pop);

        if (!Test_en) begin
            state_d  = IDLE;
            warm_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WARMUP;
                    warm_d  = CNT_W'(CHAIN_LEN);
                end
                WARMUP: begin
                    warm_d = warm_q - CNT_W'(1);
                    if (warm_q == CNT_W'(1)) state_d = CHECK;
                end
                CHECK: begin
                    if (sc_tail && expected) begin
                        if (pulses_checked_q != '1) pulses_checked_d = pulses_checked_q + CNT_W'(1);
                    end else if (sc_tail != expected) begin
                        mismatch_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (do_pop)
                rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            if (push_ok) begin
                mem_d[wr_ptr_q] = cyc_q + CNT_W'(CHAIN_LEN);
                wr_ptr_d        = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end else if (do_push) begin
                overflow_d = 1'b1;
            end
            occ_d = occ_q + OW'(push_ok) - OW'(do_pop);
        end

        checking_d = (state_d == CHECK);
    end

    // State and output registers, cleared asynchronously by Reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q          <= IDLE;
            cyc_q            <= '0;
            warm_q           <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            occ_q            <= '0;
            mismatch_q       <= 1'b0;
            err_count_q      <= '0;
            pulses_checked_q <= '0;
            overflow_q       <= 1'b0;
            checking_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cyc_q            <= cyc_d;
            warm_q           <= warm_d;
            mem_q            <= mem_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            occ_q            <= occ_d;
            mismatch_q       <= mismatch_d;
            err_count_q      <= err_count_d;
            pulses_checked_q <= pulses_checked_d;
            overflow_q       <= overflow_d;
            checking_q       <= checking_d;
        end
    end

    assign mismatch       = mismatch_q;
    assign err_count      = err_count_q;
    assign pulses_checked = pulses_checked_q;
    assign overflow       = overflow_q;
    assign checking       = checking_q;

endmodule

// File: tb/tb_sc_chain_monitor.sv
// Bench for sc_chain_monitor: an external scan chain is modelled as a head
// history delayed by a chosen number of stages; outputs are compared each
// cycle against a pulse-arrival reference model.
module tb_sc_chain_monitor;
    localparam int unsigned L    = 80;
    localparam int unsigned D    = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned EW   = 6;
    localparam int unsigned VW   = 1 + EW + CW + 1 + 1;
    localparam int          EMAX = (1 << EW) - 1;
    localparam int          PMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          Reset, Test_en, sc_head, sc_tail;
    logic          mismatch;
    logic [EW-1:0] err_count;
    logic [CW-1:0] pulses_checked;
    logic          overflow, checking;

    sc_chain_monitor #(.CHAIN_LEN(L), .DEPTH(D), .CNT_W(CW), .ERR_W(EW)) dut (
        .clk(clk), .Reset(Reset), .Test_en(Test_en), .sc_head(sc_head), .sc_tail(sc_tail),
        .mismatch(mismatch), .err_count(err_count), .pulses_checked(pulses_checked),
        .overflow(overflow), .checking(checking)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // external chain
    bit          hist [0:32767];
    int          now = 0;
    int          stages = 80;
    int          force_tail = -1;
    int unsigned flip_pct = 0;

    // reference model: run = consecutive enabled edges since last IDLE
    int m_t, m_run, m_err, m_pc;
    bit m_mis, m_ovf, m_chk;
    int m_q[$];

    function automatic logic [VW-1:0] model_vec();
        return {m_mis, EW'(m_err), CW'(m_pc), m_ovf, m_chk};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {mismatch, err_count, pulses_checked, overflow, checking};
    endfunction

    task automatic model_reset();
        m_t = 0; m_run = 0; m_err = 0; m_pc = 0;
        m_mis = 0; m_ovf = 0; m_chk = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit en, input bit head, input bit tail);
        bit exp_hit;
        m_mis = 0;
        if (!en) begin
            m_run = 0;
            m_q.delete();
        end else begin
            m_run++;
            if (m_run >= 2) begin
                exp_hit = (m_q.size() > 0) && (m_q[0] == m_t);
                if (exp_hit) void'(m_q.pop_front());
                if (m_run >= int'(L) + 2) begin
                    if (tail && exp_hit) begin
                        if (m_pc < PMAX) m_pc++;
                    end else if (tail != exp_hit) begin
                        m_mis = 1;
                        if (m_err < EMAX) m_err++;
                    end
                end
                if (head) begin
                    if (m_q.size() < int'(D)) m_q.push_back(m_t + int'(L));
                    else m_ovf = 1;
                end
            end
        end
        m_chk = en && (m_run >= int'(L) + 1);
        m_t++;
    endtask

    task automatic step(input bit en, input bit head);
        bit tail;
        if (force_tail >= 0) tail = (force_tail != 0);
        else tail = (now >= stages) ? hist[now - stages] : 1'b0;
        if (flip_pct > 0 && $urandom_range(99, 0) < flip_pct) tail = ~tail;
        Test_en = en; sc_head = head; sc_tail = tail;
        hist[now] = head;
        @(posedge clk);
        model_edge(en, head, tail);
        now++;
        #1;
    endtask

    task automatic reset_dut();
        Test_en = 0; sc_head = 0;
        Reset = 1;
        #2;
        Reset = 0;
        model_reset();
        stages = 80; force_tail = -1; flip_pct = 0;
    endtask

    task automatic test_reset();
        Reset = 0; Test_en = 0; sc_head = 0; sc_tail = 0;
        #2 Reset = 1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== '0) begin
            errors++; $display("FAIL reset_async got=%h exp=0", dut_vec());
        end
        @(posedge clk); #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++; $display("FAIL reset_held got=%h exp=0", dut_vec());
        end
        Reset = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_ideal();
        int phase;
        reset_dut();
        phase = int'($urandom_range(19, 0));
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, (i % 20) == phase);
            checks++;
            if (dut_vec() !== model_vec() || mismatch !== 1'b0) begin
                errors++; $display("FAIL ideal t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        checks++;
        if (err_count !== '0 || overflow !== 1'b0 || pulses_checked !== CW'(m_pc)) begin
            errors++; $display("FAIL ideal_final err=%0d ovf=%0b pc=%0d exp err=0 ovf=0 pc=%0d",
                               err_count, overflow, pulses_checked, m_pc);
        end
    endtask

    task automatic test_short_chain();
        reset_dut();
        stages = 79;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, (i % 20) == 7);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL short_chain t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        checks++;
        if (pulses_checked !== '0 || err_count !== EW'(m_err)) begin
            errors++; $display("FAIL short_chain_final pc=%0d err=%0d exp pc=0 err=%0d",
                               pulses_checked, err_count, m_err);
        end
        stages = 80;
    endtask

    task automatic test_warmup_tail();
        reset_dut();
        force_tail = 1;
        for (int k = 1; k <= int'(L) + 2; k++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL warmup t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
            checks++;
            if (mismatch !== (k == int'(L) + 2) || checking !== (k >= int'(L) + 1)) begin
                errors++; $display("FAIL warmup_edge k=%0d mis=%0b chk=%0b", k, mismatch, checking);
            end
        end
        force_tail = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL warmup_after t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (overflow !== (i >= 4) || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL overflow push=%0d ovf=%0b got=%h exp=%h", i + 1, overflow, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL overflow_drain t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        checks++;
        if (overflow !== 1'b1 || pulses_checked !== CW'(4) || err_count !== EW'(2)) begin
            errors++; $display("FAIL overflow_final ovf=%0b pc=%0d err=%0d exp 1 4 2", overflow, pulses_checked, err_count);
        end
    endtask

    task automatic test_flush();
        int saved_err, saved_pc;
        reset_dut();
        for (int i = 0; i < 130; i++) begin
            step(1'b1, (i == 20) || (i == 100) || (i == 110) || (i == 120));
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL flush_pre t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        saved_err = m_err; saved_pc = m_pc;
        for (int i = 0; i < 170; i++) begin
            step(i >= 10, 1'b0);
            checks++;
            if (dut_vec() !== model_vec() || mismatch !== 1'b0) begin
                errors++; $display("FAIL flush t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        checks++;
        if (err_count !== EW'(saved_err) || pulses_checked !== CW'(saved_pc) || pulses_checked !== CW'(1)) begin
            errors++; $display("FAIL flush_retained err=%0d pc=%0d exp err=%0d pc=%0d",
                               err_count, pulses_checked, saved_err, saved_pc);
        end
    endtask

    task automatic test_reset_mid_check();
        reset_dut();
        flip_pct = 10;
        for (int i = 0; i < 130; i++) begin
            step(1'b1, (i % 20) == 3);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL midrst_pre t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        Reset = 1;
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++; $display("FAIL midrst_async got=%h exp=0", dut_vec());
        end
        Reset = 0;
        model_reset();
        flip_pct = 10;
        for (int k = 1; k <= 150; k++) begin
            step(1'b1, (k % 20) == 3);
            checks++;
            if (dut_vec() !== model_vec() || (k <= int'(L) && checking !== 1'b0)) begin
                errors++; $display("FAIL midrst_post k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        flip_pct = 0;
    endtask

    task automatic test_err_saturation();
        reset_dut();
        force_tail = 1;
        for (int i = 0; i < int'(L) + 80; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL err_sat t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        checks++;
        if (err_count !== EW'(EMAX) || mismatch !== 1'b1) begin
            errors++; $display("FAIL err_sat_final err=%0d mis=%0b exp err=%0d mis=1", err_count, mismatch, EMAX);
        end
        force_tail = -1;
    endtask

    task automatic test_pc_saturation();
        reset_dut();
        for (int i = 0; i < 5300; i++) begin
            step(1'b1, (i % 20) == 1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL pc_sat t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        checks++;
        if (pulses_checked !== CW'(PMAX) || err_count !== '0) begin
            errors++; $display("FAIL pc_sat_final pc=%0d err=%0d exp pc=%0d err=0", pulses_checked, err_count, PMAX);
        end
    endtask

    task automatic test_random();
        int off_left;
        reset_dut();
        flip_pct = 3;
        off_left = 0;
        for (int i = 0; i < 3000; i++) begin
            bit en;
            if (off_left > 0) begin
                en = 0; off_left--;
            end else begin
                en = 1;
                if ($urandom_range(299, 0) == 0) off_left = int'($urandom_range(5, 1));
            end
            step(en, $urandom_range(14, 0) == 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random t=%0d got=%h exp=%h", m_t, dut_vec(), model_vec());
            end
        end
        flip_pct = 0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_short_chain();
        test_warmup_tail();
        test_overflow();
        test_flush();
        test_reset_mid_check();
        test_err_saturation();
        test_pc_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
